// File: rtl/mem_access_unit.sv
// MEM stage: forwards EX/MEM results to MEM/WB and performs load/store accesses
// over a request/acknowledge data bus, with lane selection, load extension and alignment checks.
module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [31:0]           hi_i,
  input  logic [31:0]           lo_i,
  input  logic                  whilo_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           store_data_i,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [3:0]            mem_sel_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  stall_req_o,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  whilo_o,
  output logic                  exc_adel_o,
  output logic                  exc_ades_o,
  output logic [ADDR_W-1:0]     badvaddr_o
);
  // state | meaning
  // IDLE  | accepting instructions; ALU ops and faults retire next cycle
  // WAIT  | bus request outstanding, pipeline held until mem_ack_i
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;

  state_t              state_q;
  logic                mem_req_q, mem_we_q, kill_q;
  logic [ADDR_W-1:0]   mem_addr_q, badvaddr_q;
  logic [3:0]          mem_sel_q, op_q;
  logic [1:0]          off_q;
  logic [31:0]         mem_wdata_q, wdata_q, hi_q, lo_q;
  logic                valid_q, wreg_q, whilo_q, adel_q, ades_q;
  logic [REG_ADDR_W-1:0] wd_q;

  logic        is_load_d, is_store_d, misalign_d, accept_d, issue_d, ack_kill_d;
  logic [1:0]  off_d, byte_lane_d;
  logic [3:0]  sel_d;
  logic [31:0] bus_wdata_d, load_data_d;
  logic [7:0]  rbyte_d;
  logic [15:0] rhalf_d;

  always_comb begin
    off_d       = mem_addr_i[1:0];
    is_load_d   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
    is_store_d  = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    misalign_d  = 1'b0;
    sel_d       = 4'b1111;
    bus_wdata_d = store_data_i;
    case (mem_op_i)
      OP_LB, OP_LBU, OP_SB: begin
        sel_d       = BIG_ENDIAN ? (4'b1000 >> off_d) : (4'b0001 << off_d);
        bus_wdata_d = {4{store_data_i[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        misalign_d  = off_d[0];
        sel_d       = (off_d[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
        bus_wdata_d = {2{store_data_i[15:0]}};
      end
      OP_LW, OP_SW: misalign_d = |off_d;
      default: ;
    endcase
    accept_d   = valid_i && !flush_i;
    issue_d    = accept_d && (is_load_d || is_store_d) && !misalign_d;
    ack_kill_d = kill_q || flush_i;

    // Extraction uses the offset/op latched at issue so it matches the bus lanes driven
    byte_lane_d = BIG_ENDIAN ? (2'd3 - off_q) : off_q;
    rbyte_d     = mem_rdata_i[{byte_lane_d, 3'b000} +: 8];
    rhalf_d     = (off_q[1] ^ BIG_ENDIAN) ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (op_q)
      OP_LB:   load_data_d = {{24{rbyte_d[7]}}, rbyte_d};
      OP_LBU:  load_data_d = {24'd0, rbyte_d};
      OP_LH:   load_data_d = {{16{rhalf_d[15]}}, rhalf_d};
      OP_LHU:  load_data_d = {16'd0, rhalf_d};
      default: load_data_d = mem_rdata_i;
    endcase

    if (rst)                 stall_req_o = 1'b0;
    else if (state_q == IDLE) stall_req_o = issue_d;
    else                     stall_req_o = !mem_ack_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_sel_q   <= '0;
      mem_wdata_q <= '0;
      op_q        <= '0;
      off_q       <= '0;
      kill_q      <= 1'b0;
      valid_q     <= 1'b0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      wdata_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      whilo_q     <= 1'b0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      badvaddr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wd_q       <= wd_i;
          wdata_q    <= wdata_i;
          hi_q       <= hi_i;
          lo_q       <= lo_i;
          badvaddr_q <= mem_addr_i;
          kill_q     <= 1'b0;
          adel_q     <= accept_d && misalign_d && is_load_d;
          ades_q     <= accept_d && misalign_d && is_store_d;
          if (issue_d) begin
            valid_q     <= 1'b0;
            wreg_q      <= 1'b0;
            whilo_q     <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_store_d;
            mem_addr_q  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            mem_sel_q   <= sel_d;
            mem_wdata_q <= bus_wdata_d;
            op_q        <= mem_op_i;
            off_q       <= off_d;
            state_q     <= WAIT;
          end else begin
            valid_q <= accept_d;
            wreg_q  <= accept_d && wreg_i && !misalign_d;
            whilo_q <= accept_d && whilo_i && !misalign_d;
          end
        end
        WAIT: begin
          adel_q  <= 1'b0;
          ades_q  <= 1'b0;
          valid_q <= 1'b0;
          wreg_q  <= 1'b0;
          whilo_q <= 1'b0;
          if (flush_i) kill_q <= 1'b1;
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            kill_q    <= 1'b0;
            state_q   <= IDLE;
            valid_q   <= !ack_kill_d;
            wreg_q    <= !ack_kill_d && !mem_we_q && wreg_i;
            whilo_q   <= !ack_kill_d && whilo_i;
            wd_q      <= wd_i;
            wdata_q   <= mem_we_q ? wdata_i : load_data_d;
            hi_q      <= hi_i;
            lo_q      <= lo_i;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_wdata_o = mem_wdata_q;
  assign valid_o     = valid_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign whilo_o     = whilo_q;
  assign exc_adel_o  = adel_q;
  assign exc_ades_o  = ades_q;
  assign badvaddr_o  = badvaddr_q;
endmodule
